// File: rtl/arith_pkg.sv
// Shared arithmetic-lab package: datapath width, divider state encoding and
// the quotient returned for a divide by zero.
package arith_pkg;

    localparam int unsigned W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam logic [W-1:0] DZ_Q = 4'hF;

endpackage

// File: rtl/div_4_if.sv
// Start/busy/done handshake bundle for the 4-bit divider.
//   start_in, a_in, b_in        : request and operands (master -> slave)
//   q_out, r_out, dz_out        : registered result (slave -> master)
//   busy_out, done_out          : status decoded from divider state
interface div_4_if;
    import arith_pkg::*;

    logic         start_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] q_out;
    logic [W-1:0] r_out;
    logic         dz_out;
    logic         busy_out;
    logic         done_out;

    modport master (
        output start_in, a_in, b_in,
        input  q_out, r_out, dz_out, busy_out, done_out
    );

    modport slave (
        input  start_in, a_in, b_in,
        output q_out, r_out, dz_out, busy_out, done_out
    );

endinterface

// File: rtl/sub_4.sv
// 4-bit borrow-ripple subtractor: d_out = a_in - b_in - br_in.
//   a_in, b_in : operands
//   br_in      : borrow into bit 0
//   d_out      : difference (modulo 2^W)
//   brp_out    : borrow out of the MSB (set when a_in < b_in + br_in)
module sub_4
    import arith_pkg::*;
(
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         br_in,
    output logic [W-1:0] d_out,
    output logic         brp_out
);

    logic [W:0] br;

    assign br[0] = br_in;

    // One full-subtractor cell per bit.
    for (genvar i = 0; i < W; i++) begin : g_cell
        assign d_out[i]  = a_in[i] ^ b_in[i] ^ br[i];
        assign br[i + 1] = (~a_in[i] & b_in[i]) | (~(a_in[i] ^ b_in[i]) & br[i]);
    end

    assign brp_out = br[W];

endmodule

// File: rtl/div_4.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : div_4_if slave (start/operands in, quotient/remainder/dz/busy/done out)
// A divide by zero skips RUN and reports q=DZ_Q, r=dividend, dz=1.
module div_4
    import arith_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div_4_if.slave   bus
);

    div_state_e   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] dvd_q, dvd_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   pr_q, pr_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] r_q, r_d;
    logic         dz_q, dz_d;

    logic [W:0]   t;
    logic [W-1:0] diff;
    logic         borrow;
    logic         take;

    // pr_q[W] is always zero after a step; kept for the 5-bit partial remainder.
    logic unused_pr_msb;
    assign unused_pr_msb = pr_q[W];

    assign t = {pr_q[W-1:0], dvd_q[W-1]};

    sub_4 u_sub (
        .a_in    (t[W-1:0]),
        .b_in    (dvs_q),
        .br_in   (1'b0),
        .d_out   (diff),
        .brp_out (borrow)
    );

    // t[W] set means t >= 16 > divisor, so the subtraction always succeeds.
    assign take = t[W] | ~borrow;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start_in) begin
                    if (bus.b_in != '0) begin
                        dvd_d   = bus.a_in;
                        dvs_d   = bus.b_in;
                        pr_d    = '0;
                        quo_d   = '0;
                        cnt_d   = 2'd3;
                        state_d = StRun;
                    end else begin
                        q_d     = DZ_Q;
                        r_d     = bus.a_in;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                dvd_d = {dvd_q[W-2:0], 1'b0};
                pr_d  = take ? {1'b0, diff} : t;
                quo_d = {quo_q[W-2:0], take};
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    q_d     = quo_d;
                    r_d     = pr_d[W-1:0];
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.q_out    = q_q;
    assign bus.r_out    = r_q;
    assign bus.dz_out   = dz_q;
    assign bus.busy_out = (state_q == StRun);
    assign bus.done_out = (state_q == StDone);

endmodule

// File: tb/tb_div_4.sv
// Self-checking bench for div_4: directed vectors, handshake corner cases,
// exhaustive and random operand sweeps against an arithmetic reference.
module tb_div_4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_4_if bus ();

    div_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    // Results of the last run_op call
    logic [3:0] res_q, res_r;
    logic       res_dz;
    int         res_done_cyc;
    bit         res_busy_ok, res_hold_ok, res_pulse_ok;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model from plain arithmetic.
    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic dz);
        if (b == 0) begin
            q = 4'hF;
            r = a;
            dz = 1'b1;
        end else begin
            q = 4'(a / b);
            r = 4'(a % b);
            dz = 1'b0;
        end
    endfunction

    // Start in cycle 0 (called 1 time unit after an edge), pulse start for one cycle.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, r0;
        q0 = bus.q_out;
        r0 = bus.r_out;
        bus.start_in = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        res_done_cyc = -1;
        res_busy_ok = 1'b1;
        res_hold_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                bus.start_in = 1'b0;
                bus.a_in = ~a;
                bus.b_in = ~b;
            end
            if (bus.busy_out !== ((b != 0) && (c <= 4))) res_busy_ok = 1'b0;
            if (bus.done_out === 1'b1) begin
                res_done_cyc = c;
                break;
            end
            if (bus.q_out !== q0 || bus.r_out !== r0) res_hold_ok = 1'b0;
        end
        res_q = bus.q_out;
        res_r = bus.r_out;
        res_dz = bus.dz_out;
        tick();
        res_pulse_ok = (bus.done_out === 1'b0) && (bus.busy_out === 1'b0);
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input bit full);
        logic [3:0] eq, er;
        logic       edz;
        model(a, b, eq, er, edz);
        run_op(a, b);
        check({tag, "_done_cycle"}, res_done_cyc, (b == 0) ? 1 : 5);
        check({tag, "_q"}, res_q, eq);
        check({tag, "_r"}, res_r, er);
        check({tag, "_dz"}, res_dz, edz);
        if (b != 0) begin
            check({tag, "_invariant"}, int'(res_q) * int'(b) + int'(res_r), a);
            check({tag, "_r_lt_b"}, int'(res_r < b), 1);
        end
        if (full) begin
            check({tag, "_busy_window"}, res_busy_ok, 1);
            check({tag, "_hold_during_run"}, res_hold_ok, 1);
            check({tag, "_done_pulse"}, res_pulse_ok, 1);
        end
    endtask

    initial begin
        int done_at;
        bit busy_ok;
        bit seen_done;

        vecs[0] = '{a: 4'd13, b: 4'd4, q: 4'd3,  r: 4'd1, dz: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0};
        vecs[2] = '{a: 4'd3,  b: 4'd9, q: 4'd0,  r: 4'd3, dz: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd0, q: 4'hF,  r: 4'd7, dz: 1'b1};
        vecs[4] = '{a: 4'd12, b: 4'd5, q: 4'd2,  r: 4'd2, dz: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0, dz: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd3, q: 4'd0,  r: 4'd0, dz: 1'b0};
        vecs[7] = '{a: 4'd14, b: 4'd2, q: 4'd7,  r: 4'd0, dz: 1'b0};

        bus.start_in = 1'b0;
        bus.a_in = 4'd0;
        bus.b_in = 4'd0;

        // Reset state
        repeat (2) tick();
        check("reset_q", bus.q_out, 0);
        check("reset_r", bus.r_out, 0);
        check("reset_dz", bus.dz_out, 0);
        check("reset_busy", bus.busy_out, 0);
        check("reset_done", bus.done_out, 0);
        rst = 1'b0;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_done_cycle", i), res_done_cyc, (vecs[i].b == 0) ? 1 : 5);
            check($sformatf("vec%0d_q", i), res_q, vecs[i].q);
            check($sformatf("vec%0d_r", i), res_r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), res_dz, vecs[i].dz);
            check($sformatf("vec%0d_busy_window", i), res_busy_ok, 1);
            check($sformatf("vec%0d_hold_during_run", i), res_hold_ok, 1);
            check($sformatf("vec%0d_done_pulse", i), res_pulse_ok, 1);
        end

        // Start held through RUN, operands changed mid-run; DONE accepts the second op.
        bus.start_in = 1'b1;
        bus.a_in = 4'd9;
        bus.b_in = 4'd2;
        done_at = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) begin
                bus.a_in = 4'd14;
                bus.b_in = 4'd3;
            end
            if (bus.busy_out !== (c <= 4)) busy_ok = 1'b0;
            if (bus.done_out === 1'b1 && done_at < 0) done_at = c;
        end
        check("held_first_done_cycle", done_at, 5);
        check("held_first_busy", busy_ok, 1);
        check("held_first_q", bus.q_out, 4);
        check("held_first_r", bus.r_out, 1);
        done_at = -1;
        busy_ok = 1'b1;
        for (int c = 6; c <= 12; c++) begin
            tick();
            if (c == 6) bus.start_in = 1'b0;
            if (c <= 10 && bus.busy_out !== (c <= 9)) busy_ok = 1'b0;
            if (bus.done_out === 1'b1 && done_at < 0) done_at = c;
        end
        check("held_second_done_cycle", done_at, 10);
        check("held_second_busy", busy_ok, 1);
        check("held_second_q", bus.q_out, 4);
        check("held_second_r", bus.r_out, 2);

        // Reset asserted mid-run aborts immediately.
        bus.start_in = 1'b1;
        bus.a_in = 4'd12;
        bus.b_in = 4'd5;
        tick();
        bus.start_in = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort_q", bus.q_out, 0);
        check("abort_r", bus.r_out, 0);
        check("abort_busy", bus.busy_out, 0);
        check("abort_done", bus.done_out, 0);
        tick();
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.done_out === 1'b1 || bus.busy_out === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_activity", seen_done, 0);
        run_and_check("after_abort", 4'd12, 4'd5, 1'b1);

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_and_check($sformatf("sweep_%0d_%0d", a, b), 4'(a), 4'(b), 1'b0);
            end
        end

        // Random operands with full handshake checks
        for (int k = 0; k < 40; k++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_and_check($sformatf("rand%0d_%0d_%0d", k, ra, rb), ra, rb, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
